// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, frame width and default bit period.
// Used by uart_rx (and uart_tx on the same clock domain).
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity bit over a data word: set when the word has an odd number of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async serial line plus falling-edge detect.
// All flops reset to 1 so an idle line never looks like a start edge out of reset.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Only a 1 -> 0 transition counts; a line held low never retriggers.
  assign rx_sync_o = sync_q;
  assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic line;
  logic fall;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (rx),
    .rx_sync_o (line),
    .fall_o    (fall)
  );

  uart_state_e          state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q,     par_d;
  logic                 perr_q,    perr_d;
  logic                 par_bad;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  // Datapath only: contents are don't-care until a full frame has been shifted in.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
    par_bad   = (par_q != even_parity(shift_q));
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Half a bit in: a high line here means the edge was a glitch.
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = line ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = line;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // Strobes land on the same edge as the return to IDLE, so they never overlap busy.
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          ferr_d  = ~line;
`ifdef UART_RX_PARITY_EN
          perr_d  = par_bad;
          if (line && !par_bad) begin
`else
          if (line) begin
`endif
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != ST_IDLE);
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, glitch and mid-frame reset sequences,
// then randomized frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int CPB  = 434;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  // Line falling edge to rx_valid: sync + half start bit + data (+parity) + stop bits.
  localparam int LATENCY = 3 + HALF + (9 + PAR_EN) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, viol_cnt = 0;
  logic [7:0]  last_vdata = 8'h00;
  int unsigned last_vcyc = 0;
  int unsigned frame_t0 = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt  <= valid_cnt + 1;
      last_vdata <= rx_data;
      last_vcyc  <= cyc;
    end
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if ((rx_valid || frame_err || parity_err) && rx_busy) viol_cnt <= viol_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic flip);
    frame_t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN != 0) drive_bit((^d) ^ flip);
    drive_bit(stop_b);
    rx = 1'b1;
  endtask

  // Frame-level reference: what a receiver must report for one whole frame.
  task automatic model(input logic [7:0] d, input logic stop_b, input logic flip,
                       inout logic [7:0] good, output logic ev, output logic ef, output logic ep);
    logic par_ok;
    par_ok = (PAR_EN == 0) || !flip;
    ev = stop_b && par_ok;
    ef = !stop_b;
    ep = (PAR_EN != 0) && flip;
    if (ev) good = d;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_b,
                           input logic flip, input int gap, input logic ev, input logic ef,
                           input logic ep, input logic [7:0] ed);
    int v0, f0, p0;
    v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(d, stop_b, flip);
    check({tag, " valid_pulses"}, valid_cnt - v0, {31'd0, ev});
    check({tag, " frame_err_pulses"}, ferr_cnt - f0, {31'd0, ef});
    check({tag, " parity_err_pulses"}, perr_cnt - p0, {31'd0, ep});
    check({tag, " rx_data"}, rx_data, ed);
    check({tag, " busy_after"}, rx_busy, 1'b0);
    if (ev) begin
      check({tag, " strobe_data"}, last_vdata, d);
      check({tag, " latency"}, last_vcyc - frame_t0, LATENCY);
    end
    repeat (gap) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop_b;
    logic       flip;
    int         gap;
    logic       ev;
    logic       ef;
    logic       ep;
    logic [7:0] ed;
  } vec_t;

  initial begin
    #2400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[$];
    logic [7:0] good;
    int         v0, f0, p0;
    logic [7:0] d;
    logic       stop_b, flip, ev, ef, ep;
    int         gap;

    tbl.push_back('{8'hA5, 1'b1, 1'b0, 50, 1'b1, 1'b0, 1'b0, 8'hA5});
    tbl.push_back('{8'h00, 1'b1, 1'b0,  0, 1'b1, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 50, 1'b1, 1'b0, 1'b0, 8'hFF});
    tbl.push_back('{8'h3C, 1'b0, 1'b0, 50, 1'b0, 1'b1, 1'b0, 8'hFF});
    tbl.push_back('{8'h96, 1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b0, 8'h96});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h81, 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b1, 8'h96});
    tbl.push_back('{8'h81, 1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b0, 8'h81});
    tbl.push_back('{8'h5A, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b1, 8'h81});
`endif

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset rx_busy", rx_busy, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++)
      run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop_b, tbl[i].flip, tbl[i].gap,
                tbl[i].ev, tbl[i].ef, tbl[i].ep, tbl[i].ed);
    good = tbl[tbl.size()-1].ed;

    // 100 ns low glitch on an idle line
    v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check("glitch busy_rises", rx_busy, 1'b1);
    repeat (CPB) @(negedge clk);
    check("glitch busy_after", rx_busy, 1'b0);
    check("glitch valid_pulses", valid_cnt - v0, 0);
    check("glitch err_pulses", (ferr_cnt - f0) + (perr_cnt - p0), 0);
    check("glitch rx_data", rx_data, good);

    // Reset in the middle of the data bits of 0x5A
    v0 = valid_cnt; f0 = ferr_cnt;
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (HALF) @(negedge clk);
    reset = 1'b1;
    repeat (CPB - HALF) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN != 0) drive_bit(^d);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset busy", rx_busy, 1'b0);
    check("midreset rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset valid_pulses", valid_cnt - v0, 0);
    check("midreset ferr_pulses", ferr_cnt - f0, 0);
    good = 8'h00;
    run_frame("after_reset", 8'hC3, 1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b0, 8'hC3);
    good = 8'hC3;

    // Randomized frames against the reference model
    for (int i = 0; i < 4; i++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      flip   = (PAR_EN != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      gap    = stop_b ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 40));
      model(d, stop_b, flip, good, ev, ef, ep);
      run_frame($sformatf("rand%0d", i), d, stop_b, flip, gap, ev, ef, ep, good);
    end

    check("strobe_with_busy", viol_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
